// File: rtl/ext_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ext_bus_sequencer
// Purpose  : Sequences CPU bus cycles onto a multiplexed ADH/ADL/WAIT/DATA pin bus.
// Revision : 1.0
// ============================================================================
module ext_bus_sequencer #(
  parameter int BUS_WIDTH     = 8,
  parameter int ADDRESS_WIDTH = 16,  // must equal 2*BUS_WIDTH
  parameter int WAIT_CYCLES   = 1    // 0..15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_cpu_req,
  input  logic [ADDRESS_WIDTH-1:0] i_cpu_addr,
  input  logic                     i_cpu_rw,
  input  logic [BUS_WIDTH-1:0]     i_cpu_wdata,
  output logic                     o_cpu_rdy,
  output logic [BUS_WIDTH-1:0]     o_cpu_rdata,
  output logic                     o_cpu_rvalid,
  output logic [BUS_WIDTH-1:0]     o_ext_data_out,
  input  logic [BUS_WIDTH-1:0]     i_ext_data_in,
  output logic [BUS_WIDTH-1:0]     o_ext_oe,
  output logic                     o_ext_ale_hi,
  output logic                     o_ext_ale_lo,
  output logic                     o_ext_re,
  output logic                     o_ext_we
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADH  = 3'd1,
    S_ADL  = 3'd2,
    S_WAIT = 3'd3,
    S_DATA = 3'd4
  } state_t;

  localparam logic [3:0]           c_WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam logic [BUS_WIDTH-1:0] c_DRIVE     = '1;

  state_t                     r_state;
  state_t                     w_next;
  logic [ADDRESS_WIDTH-1:0]   r_a_q;
  logic                       r_rw_q;
  logic [BUS_WIDTH-1:0]       r_wd_q;
  logic                       r_hi_valid;
  logic [BUS_WIDTH-1:0]       r_last_hi;
  logic [3:0]                 r_wait_cnt;
  logic [BUS_WIDTH-1:0]       r_rdata;
  logic                       r_rvalid;
  logic                       w_hi_hit;

  assign w_hi_hit     = r_hi_valid && (i_cpu_addr[ADDRESS_WIDTH-1:BUS_WIDTH] == r_last_hi);
  assign o_cpu_rdata  = r_rdata;
  assign o_cpu_rvalid = r_rvalid;

  always_comb begin
    w_next         = r_state;
    o_cpu_rdy      = 1'b0;
    o_ext_data_out = '0;
    o_ext_oe       = '0;
    o_ext_ale_hi   = 1'b0;
    o_ext_ale_lo   = 1'b0;
    o_ext_re       = 1'b0;
    o_ext_we       = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_cpu_rdy = 1'b1;
        if (i_cpu_req) w_next = w_hi_hit ? S_ADL : S_ADH;
      end
      S_ADH: begin
        o_ext_data_out = r_a_q[ADDRESS_WIDTH-1:BUS_WIDTH];
        o_ext_oe       = c_DRIVE;
        o_ext_ale_hi   = 1'b1;
        w_next         = S_ADL;
      end
      S_ADL: begin
        o_ext_data_out = r_a_q[BUS_WIDTH-1:0];
        o_ext_oe       = c_DRIVE;
        o_ext_ale_lo   = 1'b1;
        w_next         = (WAIT_CYCLES > 0) ? S_WAIT : S_DATA;
      end
      S_WAIT, S_DATA: begin
        // Reads release the bus; writes keep driving the write data.
        if (r_rw_q) begin
          o_ext_re = 1'b1;
        end else begin
          o_ext_we       = 1'b1;
          o_ext_oe       = c_DRIVE;
          o_ext_data_out = r_wd_q;
        end
        if (r_state == S_DATA)        w_next = S_IDLE;
        else if (r_wait_cnt <= 4'd1)  w_next = S_DATA;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_a_q      <= '0;
      r_rw_q     <= 1'b0;
      r_wd_q     <= '0;
      r_hi_valid <= 1'b0;
      r_last_hi  <= '0;
      r_wait_cnt <= '0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rvalid <= (r_state == S_DATA) && r_rw_q;
      if (r_state == S_IDLE && i_cpu_req) begin
        r_a_q  <= i_cpu_addr;
        r_rw_q <= i_cpu_rw;
        r_wd_q <= i_cpu_wdata;
      end
      if (r_state == S_ADH) begin
        r_last_hi  <= r_a_q[ADDRESS_WIDTH-1:BUS_WIDTH];
        r_hi_valid <= 1'b1;
      end
      // Counter holds the remaining WAIT cycles including the current one.
      if (r_state == S_ADL)                           r_wait_cnt <= c_WAIT_LOAD;
      else if (r_state == S_WAIT && r_wait_cnt != 0)  r_wait_cnt <= r_wait_cnt - 4'd1;
      if (r_state == S_DATA && r_rw_q) r_rdata <= i_ext_data_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ext_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_bus_sequencer
// Purpose  : Scoreboard bench for ext_bus_sequencer at WAIT_CYCLES of 1, 0 and 3.
// Revision : 1.0
// ============================================================================
module tb_ext_bus_sequencer;

  typedef struct packed {
    logic       rdy;
    logic       rvalid;
    logic       ahi;
    logic       alo;
    logic       re;
    logic       we;
    logic [7:0] oe;
    logic [7:0] dout;
  } phase_t;

  logic        clk;
  logic        rst_n;
  logic        req    [3];
  logic [15:0] addr   [3];
  logic        rw     [3];
  logic [7:0]  wd     [3];
  logic [7:0]  din    [3];
  logic        rdy    [3];
  logic [7:0]  rdata  [3];
  logic        rvalid [3];
  logic [7:0]  dout   [3];
  logic [7:0]  oe     [3];
  logic        ahi    [3];
  logic        alo    [3];
  logic        re     [3];
  logic        we     [3];

  int          checks = 0;
  int          errors = 0;
  phase_t      exp_q[$];
  logic        mhv [3];
  logic [7:0]  mlh [3];
  logic [7:0]  mrd [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ext_bus_sequencer #(
      .BUS_WIDTH    (8),
      .ADDRESS_WIDTH(16),
      .WAIT_CYCLES  ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_cpu_req     (req[g]),
      .i_cpu_addr    (addr[g]),
      .i_cpu_rw      (rw[g]),
      .i_cpu_wdata   (wd[g]),
      .o_cpu_rdy     (rdy[g]),
      .o_cpu_rdata   (rdata[g]),
      .o_cpu_rvalid  (rvalid[g]),
      .o_ext_data_out(dout[g]),
      .i_ext_data_in (din[g]),
      .o_ext_oe      (oe[g]),
      .o_ext_ale_hi  (ahi[g]),
      .o_ext_ale_lo  (alo[g]),
      .o_ext_re      (re[g]),
      .o_ext_we      (we[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wc(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  // Pin bus value is only meaningful while the sequencer drives it.
  function automatic phase_t obs(input int k);
    phase_t p;
    p.rdy = rdy[k]; p.rvalid = rvalid[k]; p.ahi = ahi[k]; p.alo = alo[k];
    p.re = re[k]; p.we = we[k]; p.oe = oe[k];
    p.dout = (oe[k] == 8'h00) ? 8'h00 : dout[k];
    return p;
  endfunction

  function automatic phase_t idle_ph(input logic v);
    phase_t p;
    p = '0; p.rdy = 1'b1; p.rvalid = v;
    return p;
  endfunction

  function automatic void reset_model();
    for (int k = 0; k < 3; k++) begin
      mhv[k] = 1'b0; mlh[k] = 8'h00; mrd[k] = 8'h00;
    end
    exp_q.delete();
  endfunction

  // Drives one request (caller is at a negedge with the DUT idle) and queues its pin phases.
  task automatic issue(input int k, input logic [15:0] a, input logic r,
                       input logic [7:0] w, input logic [7:0] d);
    phase_t p;
    req[k] = 1'b1; addr[k] = a; rw[k] = r; wd[k] = w; din[k] = d;
    if (!(mhv[k] && mlh[k] == a[15:8])) begin
      p = '0; p.ahi = 1'b1; p.oe = 8'hFF; p.dout = a[15:8];
      exp_q.push_back(p);
      mhv[k] = 1'b1; mlh[k] = a[15:8];
    end
    p = '0; p.alo = 1'b1; p.oe = 8'hFF; p.dout = a[7:0];
    exp_q.push_back(p);
    for (int i = 0; i <= wc(k); i++) begin
      p = '0;
      if (r) p.re = 1'b1;
      else begin p.we = 1'b1; p.oe = 8'hFF; p.dout = w; end
      exp_q.push_back(p);
    end
    if (r) mrd[k] = d;
    @(posedge clk);
    #1 req[k] = 1'b0;
  endtask

  task automatic test_reset();
    phase_t o;
    for (int k = 0; k < 3; k++) begin
      o = obs(k);
      checks++;
      if (o !== idle_ph(1'b0)) begin
        errors++; $display("FAIL reset_pins[%0d] got %h want %h", k, o, idle_ph(1'b0));
      end
      checks++;
      if (rdata[k] !== 8'h00 || dout[k] !== 8'h00) begin
        errors++; $display("FAIL reset_data[%0d] got rdata %h dout %h want 00 00", k, rdata[k], dout[k]);
      end
    end
  endtask

  task automatic test_read_first();
    phase_t e, o;
    issue(0, 16'h1234, 1'b1, 8'h00, 8'hA5);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front(); o = obs(0); checks++;
      if (o !== e) begin errors++; $display("FAIL read_first phase got %h want %h", o, e); end
    end
    @(negedge clk);
    o = obs(0); checks++;
    if (o !== idle_ph(1'b1)) begin errors++; $display("FAIL read_first done got %h want %h", o, idle_ph(1'b1)); end
    checks++;
    if (rdata[0] !== mrd[0]) begin errors++; $display("FAIL read_first rdata got %h want %h", rdata[0], mrd[0]); end
  endtask

  task automatic test_write_same_page();
    phase_t e, o;
    issue(0, 16'h1235, 1'b0, 8'h3C, 8'hEE);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front(); o = obs(0); checks++;
      if (o !== e) begin errors++; $display("FAIL write_page phase got %h want %h", o, e); end
    end
    @(negedge clk);
    o = obs(0); checks++;
    if (o !== idle_ph(1'b0)) begin errors++; $display("FAIL write_page done got %h want %h", o, idle_ph(1'b0)); end
    checks++;
    if (rdata[0] !== mrd[0]) begin errors++; $display("FAIL write_page rdata got %h want %h", rdata[0], mrd[0]); end
  endtask

  // Second read issued in the single IDLE cycle: no dead cycle, and the page change emits ADH.
  task automatic test_back_to_back();
    phase_t e, o;
    logic [15:0] a_tab [2];
    logic [7:0]  d_tab [2];
    a_tab[0] = 16'h12FF; d_tab[0] = 8'h5A;
    a_tab[1] = 16'h1300; d_tab[1] = 8'hC3;
    @(negedge clk);
    for (int t = 0; t < 2; t++) begin
      issue(0, a_tab[t], 1'b1, 8'h00, d_tab[t]);
      while (exp_q.size() > 0) begin
        @(negedge clk);
        e = exp_q.pop_front(); o = obs(0); checks++;
        if (o !== e) begin errors++; $display("FAIL b2b[%0d] phase got %h want %h", t, o, e); end
      end
      @(negedge clk);
      o = obs(0); checks++;
      if (o !== idle_ph(1'b1)) begin errors++; $display("FAIL b2b[%0d] done got %h want %h", t, o, idle_ph(1'b1)); end
      checks++;
      if (rdata[0] !== mrd[0]) begin errors++; $display("FAIL b2b[%0d] rdata got %h want %h", t, rdata[0], mrd[0]); end
    end
  endtask

  task automatic test_reset_mid();
    phase_t e, o;
    @(negedge clk);
    issue(0, 16'h1340, 1'b0, 8'h77, 8'h00);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      e = exp_q.pop_front(); o = obs(0); checks++;
      if (o !== e) begin errors++; $display("FAIL rst_mid pre phase got %h want %h", o, e); end
    end
    #2 rst_n = 1'b0;
    #1;
    reset_model();
    o = obs(0); checks++;
    if (o !== idle_ph(1'b0)) begin errors++; $display("FAIL rst_mid async got %h want %h", o, idle_ph(1'b0)); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, 16'h1340, 1'b1, 8'h00, 8'h9E);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front(); o = obs(0); checks++;
      if (o !== e) begin errors++; $display("FAIL rst_mid post phase got %h want %h", o, e); end
    end
    @(negedge clk);
    o = obs(0); checks++;
    if (o !== idle_ph(1'b1)) begin errors++; $display("FAIL rst_mid done got %h want %h", o, idle_ph(1'b1)); end
    checks++;
    if (rdata[0] !== mrd[0]) begin errors++; $display("FAIL rst_mid rdata got %h want %h", rdata[0], mrd[0]); end
  endtask

  task automatic test_wait_variants();
    phase_t e, o;
    int          k_tab [6];
    logic [15:0] a_tab [6];
    logic        r_tab [6];
    logic [7:0]  d_tab [6];
    k_tab = '{1, 1, 2, 2, 2, 2};
    a_tab = '{16'hABCD, 16'hAB00, 16'h0F0F, 16'h1000, 16'hFF01, 16'h0002};
    r_tab = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    d_tab = '{8'h42, 8'h11, 8'h66, 8'h55, 8'h81, 8'h18};
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      issue(k_tab[t], a_tab[t], r_tab[t], d_tab[t], d_tab[t]);
      while (exp_q.size() > 0) begin
        @(negedge clk);
        e = exp_q.pop_front(); o = obs(k_tab[t]); checks++;
        if (o !== e) begin errors++; $display("FAIL wait[%0d] phase got %h want %h", t, o, e); end
      end
      @(negedge clk);
      o = obs(k_tab[t]); checks++;
      if (o !== idle_ph(r_tab[t])) begin
        errors++; $display("FAIL wait[%0d] done got %h want %h", t, o, idle_ph(r_tab[t]));
      end
      checks++;
      if (rdata[k_tab[t]] !== mrd[k_tab[t]]) begin
        errors++; $display("FAIL wait[%0d] rdata got %h want %h", t, rdata[k_tab[t]], mrd[k_tab[t]]);
      end
    end
  endtask

  task automatic test_busy_toggle();
    phase_t e, o;
    @(negedge clk);
    issue(0, 16'h1350, 1'b1, 8'h00, 8'hB7);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front(); o = obs(0); checks++;
      if (o !== e) begin errors++; $display("FAIL busy_toggle phase got %h want %h", o, e); end
      req[0]  = ~req[0];
      addr[0] = 16'($urandom);
      rw[0]   = 1'($urandom);
    end
    @(negedge clk);
    req[0] = 1'b0;
    o = obs(0); checks++;
    if (o !== idle_ph(1'b1)) begin errors++; $display("FAIL busy_toggle done got %h want %h", o, idle_ph(1'b1)); end
    checks++;
    if (rdata[0] !== mrd[0]) begin errors++; $display("FAIL busy_toggle rdata got %h want %h", rdata[0], mrd[0]); end
    repeat (2) begin
      @(negedge clk);
      o = obs(0); checks++;
      if (o !== idle_ph(1'b0)) begin errors++; $display("FAIL busy_toggle extra got %h want %h", o, idle_ph(1'b0)); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; addr[k] = 16'h0000; rw[k] = 1'b0; wd[k] = 8'h00; din[k] = 8'h00;
    end
    reset_model();
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_read_first();
    test_write_same_page();
    test_back_to_back();
    test_reset_mid();
    test_wait_variants();
    test_busy_toggle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
